// File: rtl/ahb_master_req_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ahb_master_req_ctrl_pkg
// Shared AHB types for the per-master request controllers:
//   htrans_type  - master transfer type encoding
//   hburst_type  - master burst type encoding
//   req_state_e  - sequencer state of ahb_master_req_ctrl
//   burst_limit  - last-beat index of a fixed-length burst
// ---------------------------------------------------------------------------
package ahb_master_req_ctrl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_type;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } req_state_e;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WAIT_W = 8;

  // Index of the last beat of a fixed burst. INCR has no fixed length; it
  // returns the saturation value and is ended by the transfer type instead.
  function automatic logic [CNT_W-1:0] burst_limit(input hburst_type burst);
    logic [CNT_W-1:0] limit;
    case (burst)
      HBURST_SINGLE: limit = 4'd0;
      HBURST_WRAP4,
      HBURST_INCR4:  limit = 4'd3;
      HBURST_WRAP8,
      HBURST_INCR8:  limit = 4'd7;
      HBURST_WRAP16,
      HBURST_INCR16: limit = 4'd15;
      HBURST_INCR:   limit = 4'hF;
      default:       limit = 4'hF;
    endcase
    return limit;
  endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_addr_decode.sv
// ---------------------------------------------------------------------------
// ahb_addr_decode
// Maps a master address onto a slave-arbiter index taken from the top
// DEC_BIT address bits, and flags indices with no slave behind them.
//   haddr_i  in   ADDR_W   master address
//   idx_o    out  DEC_BIT  slave index
//   valid_o  out  1        idx_o < SLAVE_NUM
// ---------------------------------------------------------------------------
module ahb_addr_decode #(
  parameter int SLAVE_NUM = 6,
  parameter int ADDR_W    = 32,
  parameter int DEC_BIT   = 3
) (
  input  logic [ADDR_W-1:0]  haddr_i,
  output logic [DEC_BIT-1:0] idx_o,
  output logic               valid_o
);

  localparam logic [DEC_BIT:0] SLV_CNT = (DEC_BIT+1)'(SLAVE_NUM);

  // Low address bits carry no routing information.
  logic unused_addr_s;
  assign unused_addr_s = ^haddr_i[ADDR_W-DEC_BIT-1:0];

  assign idx_o   = haddr_i[ADDR_W-1 -: DEC_BIT];
  assign valid_o = ({1'b0, idx_o} < SLV_CNT);

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_master_req_ctrl
// Per-master request sequencer: decodes the master's address phase into a
// one-hot request to the target slave arbiter, stalls the master until the
// grant arrives, counts accepted burst beats and drops the request after the
// last one so arbitration moves on at transaction boundaries.
//   hclk      in   1          clock
//   hreset_n  in   1          asynchronous active-low reset
//   htrans    in   2          master transfer type
//   haddr     in   ADDR_W     master address
//   hburst    in   3          master burst type
//   hgrant    in   SLAVE_NUM  grant from each slave arbiter
//   hreq      out  SLAVE_NUM  one-hot request (registered)
//   hready_m  out  1          ready to the master (combinational)
//   dec_err   out  1          one-cycle decode-error pulse (registered)
//   starve    out  1          request waited REQ_TIMEOUT cycles (registered)
//   busy      out  1          sequencer not idle
// ---------------------------------------------------------------------------
module ahb_master_req_ctrl
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int SLAVE_NUM   = 6,
  parameter int ADDR_W      = 32,
  parameter int DEC_BIT     = 3,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  htrans_type           htrans,
  input  logic [ADDR_W-1:0]    haddr,
  input  hburst_type           hburst,
  input  logic [SLAVE_NUM-1:0] hgrant,
  output logic [SLAVE_NUM-1:0] hreq,
  output logic                 hready_m,
  output logic                 dec_err,
  output logic                 starve,
  output logic                 busy
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(REQ_TIMEOUT);

  req_state_e           state_q,   state_d;
  hburst_type           burst_q,   burst_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [WAIT_W-1:0]    wait_q,    wait_d;
  logic [SLAVE_NUM-1:0] hreq_q,    hreq_d;
  logic                 dec_err_q, dec_err_d;
  logic                 starve_q,  starve_d;

  logic [DEC_BIT-1:0]   idx_s;
  logic                 idx_valid_s;
  logic [SLAVE_NUM-1:0] req_onehot_s;
  logic                 tgt_grant_s;
  logic                 beat_s;
  logic                 incr_end_s;
  logic [WAIT_W-1:0]    wait_inc_s;

  ahb_addr_decode #(
    .SLAVE_NUM (SLAVE_NUM),
    .ADDR_W    (ADDR_W),
    .DEC_BIT   (DEC_BIT)
  ) u_addr_decode (
    .haddr_i (haddr),
    .idx_o   (idx_s),
    .valid_o (idx_valid_s)
  );

  assign req_onehot_s = {{(SLAVE_NUM-1){1'b0}}, 1'b1} << idx_s;
  // hreq_q is the latched one-hot target for the whole of REQ/DATA, so it
  // doubles as the mask that discards grants from other arbiters.
  assign tgt_grant_s  = |(hgrant & hreq_q);
  assign wait_inc_s   = (wait_q == WAIT_MAX) ? wait_q : wait_q + 8'd1;

  // Next-state and master-ready logic.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    hreq_d     = hreq_q;
    dec_err_d  = 1'b0;
    starve_d   = starve_q;
    hready_m   = 1'b0;
    beat_s     = 1'b0;
    incr_end_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hready_m = (htrans != HTRANS_NONSEQ);
        if (htrans == HTRANS_NONSEQ) begin
          if (idx_valid_s) begin
            state_d  = ST_REQ;
            burst_d  = hburst;
            cnt_d    = 4'd0;
            wait_d   = 8'd0;
            starve_d = 1'b0;
            hreq_d   = req_onehot_s;
          end else begin
            state_d   = ST_ERR;
            dec_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (tgt_grant_s) begin
          state_d  = ST_DATA;
          wait_d   = 8'd0;
          starve_d = 1'b0;
        end else begin
          wait_d   = wait_inc_s;
          starve_d = (wait_inc_s == WAIT_MAX);
        end
      end
      ST_DATA: begin
        hready_m = tgt_grant_s;
        beat_s   = tgt_grant_s &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
        if (burst_q == HBURST_INCR) begin
          // The held NONSEQ that opens the burst is its first beat; only a
          // NONSEQ after at least one accepted beat starts a new transfer.
          incr_end_s = tgt_grant_s &&
                       ((htrans == HTRANS_IDLE) ||
                        ((htrans == HTRANS_NONSEQ) && (cnt_q != 4'd0)));
          if (incr_end_s) begin
            state_d = ST_IDLE;
            hreq_d  = '0;
            cnt_d   = 4'd0;
          end else if (beat_s) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          if (beat_s) begin
            if (cnt_q == burst_limit(burst_q)) begin
              state_d = ST_IDLE;
              hreq_d  = '0;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        hreq_d  = '0;
        cnt_d   = 4'd0;
        wait_d  = 8'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= ST_IDLE;
      burst_q   <= HBURST_SINGLE;
      cnt_q     <= 4'd0;
      wait_q    <= 8'd0;
      hreq_q    <= '0;
      dec_err_q <= 1'b0;
      starve_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      hreq_q    <= hreq_d;
      dec_err_q <= dec_err_d;
      starve_q  <= starve_d;
    end
  end

  assign hreq    = hreq_q;
  assign dec_err = dec_err_q;
  assign starve  = starve_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_req_ctrl
// Directed stimulus for ahb_master_req_ctrl. Each driven cycle pushes the
// hand-derived outputs for that cycle into a queue; an independent monitor
// pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_master_req_ctrl;
  import ahb_master_req_ctrl_pkg::*;

  logic       hclk;
  logic       hreset_n;
  htrans_type htrans;
  logic [31:0] haddr;
  hburst_type hburst;
  logic [5:0] hgrant;
  logic [5:0] hreq;
  logic       hready_m;
  logic       dec_err;
  logic       starve;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  typedef struct {
    string      name;
    int         num;
    logic [5:0] hreq;
    logic       rdy;
    logic       derr;
    logic       starve;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ahb_master_req_ctrl #(
    .SLAVE_NUM   (6),
    .ADDR_W      (32),
    .DEC_BIT     (3),
    .REQ_TIMEOUT (255)
  ) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .htrans   (htrans),
    .haddr    (haddr),
    .hburst   (hburst),
    .hgrant   (hgrant),
    .hreq     (hreq),
    .hready_m (hready_m),
    .dec_err  (dec_err),
    .starve   (starve),
    .busy     (busy)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Drive one cycle's inputs just after the rising edge and record what the
  // outputs must be during that cycle.
  task automatic cyc(input string nm, input logic rst, input htrans_type tr,
                     input int slv, input hburst_type bu, input logic [5:0] gr,
                     input logic [5:0] e_req, input logic e_rdy,
                     input logic e_derr, input logic e_starve, input logic e_busy);
    exp_t e;
    @(posedge hclk);
    #1;
    hreset_n = rst;
    htrans   = tr;
    haddr    = {slv[2:0], 29'h0000_00A4};
    hburst   = bu;
    hgrant   = gr;
    e.name   = nm;
    e.num    = cyc_no;
    e.hreq   = e_req;
    e.rdy    = e_rdy;
    e.derr   = e_derr;
    e.starve = e_starve;
    e.busy   = e_busy;
    exp_q.push_back(e);
    cyc_no++;
  endtask

  // Scoreboard monitor.
  always @(negedge hclk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({hreq, hready_m, dec_err, starve, busy} !==
          {mon_e.hreq, mon_e.rdy, mon_e.derr, mon_e.starve, mon_e.busy}) begin
        errors++;
        $display("FAIL %s cycle %0d: got hreq=%b hready_m=%b dec_err=%b starve=%b busy=%b, expected hreq=%b hready_m=%b dec_err=%b starve=%b busy=%b",
                 mon_e.name, mon_e.num, hreq, hready_m, dec_err, starve, busy,
                 mon_e.hreq, mon_e.rdy, mon_e.derr, mon_e.starve, mon_e.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    hreset_n = 1'b0;
    htrans   = HTRANS_IDLE;
    haddr    = 32'h0;
    hburst   = HBURST_SINGLE;
    hgrant   = 6'h00;

    // Reset state and release.
    cyc("reset",     1'b0, HTRANS_IDLE,   0, HBURST_SINGLE, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("reset_rel", 1'b1, HTRANS_IDLE,   0, HBURST_SINGLE, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // SINGLE to slave 2, grant in first REQ cycle.
    cyc("single",    1'b1, HTRANS_NONSEQ, 2, HBURST_SINGLE, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("single",    1'b1, HTRANS_NONSEQ, 2, HBURST_SINGLE, 6'h04, 6'h04, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("single",    1'b1, HTRANS_NONSEQ, 2, HBURST_SINGLE, 6'h04, 6'h04, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("single",    1'b1, HTRANS_IDLE,   0, HBURST_SINGLE, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // INCR4 to slave 0, grant held.
    cyc("incr4",     1'b1, HTRANS_NONSEQ, 0, HBURST_INCR4,  6'h01, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("incr4",     1'b1, HTRANS_NONSEQ, 0, HBURST_INCR4,  6'h01, 6'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("incr4",     1'b1, HTRANS_NONSEQ, 0, HBURST_INCR4,  6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("incr4",   1'b1, HTRANS_SEQ,    0, HBURST_INCR4,  6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr4_end", 1'b1, HTRANS_IDLE,   0, HBURST_INCR4,  6'h01, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // INCR4 with two BUSY cycles mid-burst.
    cyc("incr4b",    1'b1, HTRANS_NONSEQ, 0, HBURST_INCR4,  6'h01, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("incr4b",    1'b1, HTRANS_NONSEQ, 0, HBURST_INCR4,  6'h01, 6'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("incr4b",    1'b1, HTRANS_NONSEQ, 0, HBURST_INCR4,  6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr4b",    1'b1, HTRANS_SEQ,    0, HBURST_INCR4,  6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr4b",    1'b1, HTRANS_BUSY,   0, HBURST_INCR4,  6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr4b",    1'b1, HTRANS_BUSY,   0, HBURST_INCR4,  6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr4b",    1'b1, HTRANS_SEQ,    0, HBURST_INCR4,  6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr4b",    1'b1, HTRANS_SEQ,    0, HBURST_INCR4,  6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr4b_end",1'b1, HTRANS_IDLE,   0, HBURST_INCR4,  6'h01, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // INCR8 to slave 5 with a 3-cycle slave wait after beat 5; the other
    // grant bits are raised during the wait and must be ignored.
    cyc("incr8",     1'b1, HTRANS_NONSEQ, 5, HBURST_INCR8,  6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("incr8",     1'b1, HTRANS_NONSEQ, 5, HBURST_INCR8,  6'h20, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("incr8",     1'b1, HTRANS_NONSEQ, 5, HBURST_INCR8,  6'h20, 6'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc("incr8",   1'b1, HTRANS_SEQ,    5, HBURST_INCR8,  6'h20, 6'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("incr8_wt",1'b1, HTRANS_SEQ,    5, HBURST_INCR8,  6'h1F, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("incr8",   1'b1, HTRANS_SEQ,    5, HBURST_INCR8,  6'h20, 6'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr8_end", 1'b1, HTRANS_IDLE,   0, HBURST_INCR8,  6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Decode errors: index 7 and the boundary index 6.
    for (int s = 7; s >= 6; s--) begin
      cyc("dec_err", 1'b1, HTRANS_NONSEQ, s, HBURST_SINGLE, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("dec_err", 1'b1, HTRANS_NONSEQ, s, HBURST_SINGLE, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc("dec_err", 1'b1, HTRANS_IDLE,   0, HBURST_SINGLE, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Undefined-length INCR to slave 1 ended by a NONSEQ to slave 3, which
    // is then decoded in IDLE and ended by IDLE.
    cyc("incr",      1'b1, HTRANS_NONSEQ, 1, HBURST_INCR,   6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("incr",      1'b1, HTRANS_NONSEQ, 1, HBURST_INCR,   6'h02, 6'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("incr",      1'b1, HTRANS_NONSEQ, 1, HBURST_INCR,   6'h02, 6'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr",      1'b1, HTRANS_SEQ,    1, HBURST_INCR,   6'h02, 6'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr",      1'b1, HTRANS_SEQ,    1, HBURST_INCR,   6'h02, 6'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr_ns",   1'b1, HTRANS_NONSEQ, 3, HBURST_INCR,   6'h02, 6'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr2",     1'b1, HTRANS_NONSEQ, 3, HBURST_INCR,   6'h08, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("incr2",     1'b1, HTRANS_NONSEQ, 3, HBURST_INCR,   6'h08, 6'h08, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("incr2",     1'b1, HTRANS_NONSEQ, 3, HBURST_INCR,   6'h08, 6'h08, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr2_idl", 1'b1, HTRANS_IDLE,   3, HBURST_INCR,   6'h08, 6'h08, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("incr2_end", 1'b1, HTRANS_IDLE,   0, HBURST_INCR,   6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Starvation: slave 3 withheld for 300 REQ cycles (other grants high).
    cyc("starve",    1'b1, HTRANS_NONSEQ, 3, HBURST_SINGLE, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 300; k++)
      cyc("starve",  1'b1, HTRANS_NONSEQ, 3, HBURST_SINGLE, 6'h37, 6'h08, 1'b0, 1'b0,
          (k >= 256) ? 1'b1 : 1'b0, 1'b1);
    cyc("starve_gnt",1'b1, HTRANS_NONSEQ, 3, HBURST_SINGLE, 6'h08, 6'h08, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("starve_dat",1'b1, HTRANS_NONSEQ, 3, HBURST_SINGLE, 6'h08, 6'h08, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("starve_end",1'b1, HTRANS_IDLE,   0, HBURST_SINGLE, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-INCR16 to slave 4 after beat 7.
    cyc("incr16",    1'b1, HTRANS_NONSEQ, 4, HBURST_INCR16, 6'h10, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("incr16",    1'b1, HTRANS_NONSEQ, 4, HBURST_INCR16, 6'h10, 6'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("incr16",    1'b1, HTRANS_NONSEQ, 4, HBURST_INCR16, 6'h10, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      cyc("incr16",  1'b1, HTRANS_SEQ,    4, HBURST_INCR16, 6'h10, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("mid_reset", 1'b0, HTRANS_SEQ,    4, HBURST_INCR16, 6'h10, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("post_rst",  1'b1, HTRANS_IDLE,   0, HBURST_SINGLE, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // SINGLE to slave 2 after reset with a late grant.
    cyc("single2",   1'b1, HTRANS_NONSEQ, 2, HBURST_SINGLE, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("single2",   1'b1, HTRANS_NONSEQ, 2, HBURST_SINGLE, 6'h3B, 6'h04, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("single2",   1'b1, HTRANS_NONSEQ, 2, HBURST_SINGLE, 6'h04, 6'h04, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("single2",   1'b1, HTRANS_NONSEQ, 2, HBURST_SINGLE, 6'h04, 6'h04, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("single2",   1'b1, HTRANS_IDLE,   0, HBURST_SINGLE, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Every pushed expectation must have been consumed by the monitor.
    @(negedge hclk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
